// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a 2-byte little-endian word count followed by
// 4*N payload bytes, writes the assembled little-endian words into
// instruction memory from address 0, then releases the core from reset.
module imem_boot_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          load_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          core_rst,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    PAYLOAD,
    FLUSH,
    DONE,
    ERR
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     n_q, n_d;
  logic [AW-1:0]   word_idx_q, word_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [23:0]     shift_q, shift_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            core_rst_q, core_rst_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  // Holds in_ready low until the first edge after reset releases, even though
  // the reset state is already HDR0.
  logic            armed_q;

  logic            accept;
  logic [15:0]     n_full;
  logic            n_bad;
  logic            last_word;

  assign in_ready  = armed_q && (state_q inside {HDR0, HDR1, PAYLOAD});
  assign accept    = in_valid && in_ready;
  assign n_full    = {in_data, n_q[7:0]};
  assign n_bad     = (n_full == 16'd0) || (32'(n_full) > 32'(DEPTH));
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(n_q);

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_rst  = core_rst_q;
  assign done      = done_q;
  assign err       = err_q;

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HDR0;
      n_q         <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_rst_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_rst_q  <= core_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
      armed_q     <= 1'b1;
    end
  end

  // Next-state, byte packing and write-port control; load_req overrides accept.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    core_rst_d  = core_rst_q;
    done_d      = done_q;
    err_d       = err_q;

    if (load_req) begin
      state_d    = HDR0;
      word_idx_d = '0;
      byte_idx_d = '0;
      shift_d    = '0;
      core_rst_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end else begin
      unique case (state_q)
        HDR0: begin
          if (accept) begin
            n_d     = {8'h00, in_data};
            state_d = HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            n_d = n_full;
            if (n_bad) begin
              state_d = ERR;
              err_d   = 1'b1;
            end else begin
              state_d    = PAYLOAD;
              word_idx_d = '0;
              byte_idx_d = '0;
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            if (byte_idx_q == 2'd3) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = word_idx_q;
              mem_wdata_d = {in_data, shift_q};
              byte_idx_d  = '0;
              // Index stays put on the final word so N=DEPTH never wraps it.
              if (last_word) state_d = FLUSH;
              else           word_idx_d = word_idx_q + 1'b1;
            end else begin
              unique case (byte_idx_q)
                2'd0:    shift_d[7:0]   = in_data;
                2'd1:    shift_d[15:8]  = in_data;
                default: shift_d[23:16] = in_data;
              endcase
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
        end
        FLUSH: begin
          state_d    = DONE;
          core_rst_d = 1'b1;
          done_d     = 1'b1;
        end
        DONE: ;
        ERR:  ;
        default: state_d = HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          load_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst;
  logic          done;
  logic          err;

  logic [31:0]   prog [0:DEPTH-1];
  logic [AW-1:0] wa [$];
  logic [31:0]   wd [$];
  int            total = 0;
  int            bad = 0;
  int            we_wide = 0;
  logic          we_prev = 1'b0;

  imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .load_req  (load_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Record every write and flag any write strobe wider than one cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (mem_we && we_prev) we_wide++;
    we_prev = mem_we;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(w < 200), 32'd1);
    @(negedge clk);
  endtask

  task automatic gapw(input int gap);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic load_prog(input logic [15:0] hdr, input int nw, input int gap);
    send_byte(hdr[7:0]);
    gapw(gap);
    send_byte(hdr[15:8]);
    for (int i = 0; i < nw; i++) begin
      for (int j = 0; j < 4; j++) begin
        gapw(gap);
        send_byte(prog[i][8*j +: 8]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; load_req = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #2;
    chk("ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_edge", 32'(in_ready), 32'd1);

    // Basic full-rate load
    prog[0] = 32'h0010_0013;
    prog[1] = 32'h0020_0093;
    load_prog(16'd2, 2, 0);
    chk("basic_last_we", 32'(mem_we), 32'd1);
    chk("basic_last_addr", 32'(mem_addr), 32'd1);
    chk("basic_core_rst_lo", 32'(core_rst), 32'd0);
    @(negedge clk);
    chk("basic_core_rst", 32'(core_rst), 32'd1);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_err", 32'(err), 32'd0);
    chk("basic_in_ready", 32'(in_ready), 32'd0);
    #1;
    chk("basic_nwr", 32'(wa.size()), 32'd2);
    if (wa.size() >= 2) begin
      chk("basic_a0", 32'(wa[0]), 32'd0);
      chk("basic_d0", wd[0], 32'h0010_0013);
      chk("basic_a1", 32'(wa[1]), 32'd1);
      chk("basic_d1", wd[1], 32'h0020_0093);
    end
    clear_log();

    // Backpressure gaps of 3 idle cycles between every byte
    @(negedge clk);
    pulse_req();
    load_prog(16'd2, 2, 3);
    chk("gap_last_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    chk("gap_done", 32'(done), 32'd1);
    #1;
    chk("gap_nwr", 32'(wa.size()), 32'd2);
    if (wa.size() >= 2) begin
      chk("gap_a0", 32'(wa[0]), 32'd0);
      chk("gap_d0", wd[0], 32'h0010_0013);
      chk("gap_a1", 32'(wa[1]), 32'd1);
      chk("gap_d1", wd[1], 32'h0020_0093);
    end
    chk("gap_we_width", 32'(we_wide), 32'd0);
    clear_log();

    // Bad headers: N=0, then N=DEPTH+1
    @(negedge clk);
    pulse_req();
    load_prog(16'h0000, 0, 0);
    repeat (3) @(negedge clk);
    chk("n0_err", 32'(err), 32'd1);
    chk("n0_in_ready", 32'(in_ready), 32'd0);
    chk("n0_core_rst", 32'(core_rst), 32'd0);
    pulse_req();
    chk("n0_clr_err", 32'(err), 32'd0);
    chk("n0_clr_ready", 32'(in_ready), 32'd1);
    load_prog(16'(DEPTH + 1), 0, 0);
    repeat (3) @(negedge clk);
    chk("nbig_err", 32'(err), 32'd1);
    chk("nbig_in_ready", 32'(in_ready), 32'd0);
    chk("nbig_core_rst", 32'(core_rst), 32'd0);
    #1;
    chk("bad_hdr_nwr", 32'(wa.size()), 32'd0);
    @(negedge clk);
    pulse_req();
    prog[0] = 32'h1122_3344;
    load_prog(16'd1, 1, 0);
    @(negedge clk);
    chk("recov_done", 32'(done), 32'd1);
    chk("recov_err", 32'(err), 32'd0);
    #1;
    chk("recov_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() >= 1) chk("recov_d0", wd[0], 32'h1122_3344);
    clear_log();

    // Abort mid-word after 6 payload bytes
    @(negedge clk);
    pulse_req();
    prog[0] = 32'hCAFE_F00D;
    load_prog(16'd2, 1, 0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    in_valid = 1'b0;
    pulse_req();
    prog[0] = 32'hDEAD_BEEF;
    load_prog(16'd1, 1, 0);
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd1);
    #1;
    chk("abort_nwr", 32'(wa.size()), 32'd2);
    if (wa.size() >= 2) begin
      chk("abort_a0", 32'(wa[0]), 32'd0);
      chk("abort_d0", wd[0], 32'hCAFE_F00D);
      chk("abort_a1", 32'(wa[1]), 32'd0);
      chk("abort_d1", wd[1], 32'hDEAD_BEEF);
    end
    clear_log();

    // Capacity: N=DEPTH, word i holds i
    @(negedge clk);
    pulse_req();
    for (int i = 0; i < DEPTH; i++) prog[i] = 32'(i);
    load_prog(16'(DEPTH), DEPTH, 0);
    @(negedge clk);
    chk("cap_done", 32'(done), 32'd1);
    chk("cap_core_rst", 32'(core_rst), 32'd1);
    #1;
    chk("cap_nwr", 32'(wa.size()), 32'(DEPTH));
    if (wa.size() == DEPTH) begin
      chk("cap_last_a", 32'(wa[DEPTH-1]), 32'(DEPTH - 1));
      chk("cap_last_d", wd[DEPTH-1], 32'(DEPTH - 1));
      chk("cap_mid_a", 32'(wa[517]), 32'd517);
      chk("cap_mid_d", wd[517], 32'd517);
    end
    clear_log();
    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk("arst_core_rst", 32'(core_rst), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reload from DONE
    prog[0] = 32'h0BAD_F00D;
    load_prog(16'd1, 1, 0);
    @(negedge clk);
    chk("reload_pre_done", 32'(done), 32'd1);
    clear_log();
    pulse_req();
    chk("reload_core_rst", 32'(core_rst), 32'd0);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_in_ready", 32'(in_ready), 32'd1);
    prog[0] = 32'h1357_9BDF;
    load_prog(16'd1, 1, 0);
    @(negedge clk);
    chk("reload_post_done", 32'(done), 32'd1);
    #1;
    chk("reload_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() >= 1) begin
      chk("reload_a0", 32'(wa[0]), 32'd0);
      chk("reload_d0", wd[0], 32'h1357_9BDF);
    end
    chk("we_width_all", 32'(we_wide), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle RISC-V core: loads a program into instruction memory from a byte stream, then releases the core from reset.
- Accepts a 2-byte little-endian word-count header, then 4·N payload bytes.
- Assembles little-endian 32-bit words and writes them through the instruction-memory write port starting at word address 0.
- Holds the core in reset (active-low) until the load completes.

Parameters:
- DEPTH, 1024, instruction-memory size in 32-bit words; maximum legal N.
- AW, 10, word-address width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte.
- load_req  in  1  single-cycle pulse: abort or finish the current load and restart at header.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  AW  word address of the write.
- mem_wdata  out  32  write data.
- core_rst  out  1  active-low reset to the core; low until the load is done.
- done  out  1  load completed successfully.
- err  out  1  header rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=HDR0; counters and the byte shift register clear.
  - Outputs: mem_we=0, mem_addr=0, mem_wdata=0, core_rst=0, done=0, err=0, in_ready=0.
  - in_ready rises on the first clock edge after rst deasserts.
- All outputs are registered except in_ready, which is decoded from state: 1 in HDR0, HDR1, PAYLOAD; 0 in FLUSH, DONE, ERR.
- A byte is accepted on a rising edge only when in_valid=1 and in_ready=1. in_data is sampled at that edge.
- HDR0:
  - On accept: N[7:0] is taken from in_data; go to HDR1.
- HDR1:
  - On accept: N[15:8] is taken from in_data.
  - If N=0 or N>DEPTH: go to ERR and set err=1.
  - Otherwise: go to PAYLOAD with word_idx=0 and byte_idx=0.
- PAYLOAD, byte packing:
  - Byte_idx b lands in bits [8b+7:8b].
  - On accepting byte_idx 3, in the following cycle: mem_we=1, mem_addr=word_idx, mem_wdata=assembled word. Then word_idx increments.
  - mem_we is exactly one cycle wide per word.
  - in_ready stays 1 during this write cycle, so full-rate input is sustained: one byte per cycle and one write every 4 cycles.
  - When the 4th byte of word N-1 is accepted, go to FLUSH.
- FLUSH: one cycle, in which the final write is performed (mem_we=1). Then go to DONE.
- DONE:
  - core_rst=1 and done=1, registered, both high from the edge entering DONE.
  - Timing: last byte accepted at edge k → mem_we high during cycle k..k+1 → core_rst=1 and done=1 from edge k+1.
- ERR: err=1 and core_rst=0; in_ready=0; held until load_req or reset.
- load_req=1 in any state takes precedence over byte accept on that edge:
  - state goes to HDR0; core_rst=0, done=0, err=0 from that edge.
  - A partial word is discarded and never written.
  - Memory contents already written are not cleared.
- Reset mid-load has the same effect as load_req, but is asynchronous; a pending write is dropped.
- in_valid while in_ready=0 has no effect; the byte is not consumed.
- N=DEPTH is legal: the last write goes to address DEPTH-1, and word_idx never wraps.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Test Plan:
- Reset and basic load:
  - Stimulus: hold rst=0 for 150 time units; release; stream 02 00, 13 00 10 00, 93 00 20 00 at full rate.
  - Required: writes (0, 0x00100013) and (1, 0x00200093); core_rst and done rise 1 cycle after the second write begins; err=0.
- Backpressure gaps:
  - Stimulus: the same program, with in_valid dropped for 3 cycles between every byte.
  - Required: identical writes; mem_we is always exactly one cycle wide.
- Bad headers:
  - Stimulus: header 00 00, then separately header with N=DEPTH+1.
  - Required: err=1, core_rst stays 0, in_ready=0, no mem_we.
  - Then: load_req, followed by a valid N=1 load, completes with err=0.
- Abort mid-word:
  - Stimulus: N=2; after 6 payload bytes, pulse load_req; then send a fresh N=1 load of 0xDEADBEEF.
  - Required: only writes (0, first word) and (0, 0xDEADBEEF); no write to address 1.
- Capacity and async reset:
  - Stimulus: N=DEPTH with data equal to the word index.
  - Required: the last write goes to address DEPTH-1; done=1.
  - Then: assert rst asynchronously mid-cycle. Required: core_rst=0 and done=0 immediately, without waiting for a clock edge.
- Reload from DONE:
  - Stimulus: pulse load_req while in DONE.
  - Required: core_rst=0 on the next edge; in_ready=1; the header is accepted again.
